// File: rtl/input_debouncer.sv
// input_debouncer: per-bit 2-flop sync + counter debounce for one button and N slide switches.
// Optional auto-repeat on the button press strobe when INPUT_DEBOUNCER_AUTOREPEAT_EN is defined.
`default_nettype none

module input_debouncer #(
  parameter int N_SLIDE_SWITCHES = 8,
  parameter int DEBOUNCE_CYCLES  = 10000,
  parameter int REPEAT_CYCLES    = 250000
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_btn,
  input  logic [N_SLIDE_SWITCHES-1:0] i_slide_switches,
  output logic [N_SLIDE_SWITCHES-1:0] o_slide_switches,
  output logic                        o_btn_level,
  output logic                        o_btn_pulse,
  output logic                        o_sw_changed
);

  localparam int              NI       = N_SLIDE_SWITCHES + 1;
  localparam int              BTN      = N_SLIDE_SWITCHES;
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..65535");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 16777215) begin : g_bad_repeat
    $error("REPEAT_CYCLES out of range 2..2^24-1");
  end

  // Bit BTN carries the button; the low bits are the slide switches.
  logic [NI-1:0] raw;
  logic [NI-1:0] sync_a;
  logic [NI-1:0] sync_b;
  logic [NI-1:0] stable;
  logic [NI-1:0] stable_nxt;
  logic          btn_pulse;
  logic          sw_changed;
  logic          press;
  logic          pulse_set;

  assign raw = {i_btn, i_slide_switches};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < NI; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          hit;

    assign hit           = (sync_b[i] != stable[i]) && (cnt == CNT_LAST);
    assign stable_nxt[i] = hit ? sync_b[i] : stable[i];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        cnt <= '0;
      end else if ((sync_b[i] == stable[i]) || hit) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = ~stable[BTN] & stable_nxt[BTN];

`ifdef INPUT_DEBOUNCER_AUTOREPEAT_EN
  localparam logic [23:0] RPT_LAST = 24'(REPEAT_CYCLES - 1);
  logic [23:0] rpt_cnt;
  logic        rpt_fire;

  // Only fires while the button stays accepted across this edge, so a release never strobes.
  assign rpt_fire  = stable[BTN] & stable_nxt[BTN] & (rpt_cnt == RPT_LAST);
  assign pulse_set = press | rpt_fire;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rpt_cnt <= '0;
    end else if (!stable_nxt[BTN] || press || rpt_fire) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + 24'd1;
    end
  end
`else
  assign pulse_set = press;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stable     <= '0;
      btn_pulse  <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      stable     <= stable_nxt;
      btn_pulse  <= pulse_set;
      sw_changed <= |(stable_nxt[N_SLIDE_SWITCHES-1:0] ^ stable[N_SLIDE_SWITCHES-1:0]);
    end
  end

  assign o_slide_switches = stable[N_SLIDE_SWITCHES-1:0];
  assign o_btn_level      = stable[BTN];
  assign o_btn_pulse      = btn_pulse;
  assign o_sw_changed     = sw_changed;

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed + randomized checks against a sample-history reference model.
`default_nettype none

module tb_input_debouncer;

  localparam int N = 8;
  localparam int D = 4;
  localparam int R = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         btn;
  logic [N-1:0] sw;
  logic [N-1:0] o_sw;
  logic         o_lvl;
  logic         o_pulse;
  logic         o_chg;

  int n_checks = 0;
  int n_errors = 0;

  input_debouncer #(
    .N_SLIDE_SWITCHES (N),
    .DEBOUNCE_CYCLES  (D),
    .REPEAT_CYCLES    (R)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_btn            (btn),
    .i_slide_switches (sw),
    .o_slide_switches (o_sw),
    .o_btn_level      (o_lvl),
    .o_btn_pulse      (o_pulse),
    .o_sw_changed     (o_chg)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D synchronized samples
  // (raw values taken two edges earlier) all disagree with the accepted level.
  logic [N:0]   hist[$];
  logic [N:0]   m_stable;
  logic         m_pulse;
  logic         m_chg;
  int           edge_no;
  int           press_edge;
  int           n_pulse;
  int           n_chg;
  int           n_lvl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < D + 1; k++) hist.push_back('0);
    m_stable = '0;
    m_pulse  = 1'b0;
    m_chg    = 1'b0;
  endtask

  task automatic model_edge();
    logic [N:0] nxt;
    hist.push_back({btn, sw});
    if (hist.size() > D + 2) void'(hist.pop_front());
    for (int b = 0; b <= N; b++) begin
      logic all_diff;
      all_diff = 1'b1;
      for (int k = 0; k < D; k++)
        if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
      nxt[b] = all_diff ? ~m_stable[b] : m_stable[b];
    end
    edge_no++;
    m_pulse = !m_stable[N] && nxt[N];
    if (m_pulse) press_edge = edge_no;
`ifdef INPUT_DEBOUNCER_AUTOREPEAT_EN
    else if (m_stable[N] && nxt[N] && ((edge_no - press_edge) % R == 0)) m_pulse = 1'b1;
`endif
    m_chg    = nxt[N-1:0] != m_stable[N-1:0];
    m_stable = nxt;
  endtask

  task automatic compare_all();
    check("sw_level",  32'(o_sw),    32'(m_stable[N-1:0]));
    check("btn_level", 32'(o_lvl),   32'(m_stable[N]));
    check("btn_pulse", 32'(o_pulse), 32'(m_pulse));
    check("sw_change", 32'(o_chg),   32'(m_chg));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (o_pulse) n_pulse++;
    if (o_chg)   n_chg++;
    if (o_lvl)   n_lvl++;
  endtask

  // Called at posedge+1; asserts reset between edges and releases it between edges.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    check("rst_sw",    32'(o_sw),    32'h0);
    check("rst_lvl",   32'(o_lvl),   32'h0);
    check("rst_pulse", 32'(o_pulse), 32'h0);
    check("rst_chg",   32'(o_chg),   32'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic wait_sw(input logic [N-1:0] val, output int n);
    n = 0;
    while (n < 30 && o_sw !== val) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_btn(input logic val, output int n);
    n = 0;
    while (n < 30 && o_lvl !== val) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    btn        = 1'b0;
    sw         = '0;
    edge_no    = 0;
    press_edge = 0;
    n_pulse    = 0;
    n_chg      = 0;
    n_lvl      = 0;
    model_clear();
    #3;
    check("init_sw",    32'(o_sw),    32'h0);
    check("init_lvl",   32'(o_lvl),   32'h0);
    check("init_pulse", 32'(o_pulse), 32'h0);
    check("init_chg",   32'(o_chg),   32'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) tick();

    // Switch acceptance latency and single change strobe.
    sw = 8'hA5;
    n_chg = 0;
    wait_sw(8'hA5, n);
    check("sw_latency", 32'(n), 32'd6);
    repeat (4) tick();
    check("sw_chg_count", 32'(n_chg), 32'd1);

    // Short button glitch is rejected.
    btn = 1'b1;
    n_pulse = 0;
    n_lvl = 0;
    repeat (3) tick();
    btn = 1'b0;
    repeat (10) tick();
    check("glitch_pulses", 32'(n_pulse), 32'd0);
    check("glitch_level",  32'(n_lvl),   32'd0);

    // Held press and release.
    btn = 1'b1;
    n_pulse = 0;
    wait_btn(1'b1, n);
    check("press_latency", 32'(n), 32'd6);
    check("press_pulse_now", 32'(o_pulse), 32'd1);
    btn = 1'b0;
    wait_btn(1'b0, n);
    check("release_latency", 32'(n), 32'd6);
    check("press_pulse_count", 32'(n_pulse), 32'd1);
    n_pulse = 0;
    repeat (4) tick();
    check("release_pulses", 32'(n_pulse), 32'd0);

    // Button and switches accepted on the same edge.
    sw = '0;
    do_reset();
    sw  = 8'hA5;
    btn = 1'b1;
    wait_btn(1'b1, n);
    check("same_edge_pulse", 32'(o_pulse), 32'd1);
    check("same_edge_chg",   32'(o_chg),   32'd1);
    check("same_edge_sw",    32'(o_sw),    32'hA5);

    // Reset two edges short of acceptance discards the partial count.
    btn = 1'b0;
    sw  = '0;
    do_reset();
    sw = 8'h01;
    repeat (4) tick();
    check("mid_sw_pending", 32'(o_sw), 32'h0);
    do_reset();
    wait_sw(8'h01, n);
    check("mid_reaccept_latency", 32'(n), 32'd6);

    // Long hold: one pulse, plus auto-repeat when enabled.
    sw = '0;
    do_reset();
    btn = 1'b1;
    n_pulse = 0;
    repeat (40) tick();
`ifdef INPUT_DEBOUNCER_AUTOREPEAT_EN
    check("hold_pulses", 32'(n_pulse), 32'd5);
`else
    check("hold_pulses", 32'(n_pulse), 32'd1);
`endif
    btn = 1'b0;
    n_pulse = 0;
    repeat (12) tick();
    check("after_release_pulses", 32'(n_pulse), 32'd0);
    check("after_release_level",  32'(o_lvl),   32'd0);

    // Randomized segments with glitches, long holds and occasional resets.
    for (int seg = 0; seg < 120; seg++) begin
      int hold;
      if ($urandom_range(0, 2) == 0) begin
        sw  = N'($urandom);
        btn = 1'($urandom);
      end else begin
        sw  = sw ^ (N'($urandom) & N'($urandom));
        btn = ($urandom_range(0, 3) == 0) ? ~btn : btn;
      end
      hold = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 14);
      for (int c = 0; c < hold; c++) tick();
      if ($urandom_range(0, 24) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001: Parameter N_SLIDE_SWITCHES, default 8, number of slide-switch inputs debounced.
REQ-002: Parameter DEBOUNCE_CYCLES, default 10000, consecutive disagreeing cycles required to accept a new level; legal range 1..65535.
REQ-003: Parameter REPEAT_CYCLES, default 250000, auto-repeat interval in cycles; legal range 2..2^24-1; used only with the REQ-027 macro.
REQ-004: i_clk  input  1  sole clock; all state changes on rising edge.
REQ-005: i_reset_n  input  1  asynchronous, active-low reset.
REQ-006: i_btn  input  1  raw, asynchronous push-button level, 1 = pressed.
REQ-007: i_slide_switches  input  N_SLIDE_SWITCHES  raw, asynchronous switch levels.
REQ-008: o_slide_switches  output  N_SLIDE_SWITCHES  debounced switch levels; feeds the priority encoder request vector.
REQ-009: o_btn_level  output  1  debounced button level.
REQ-010: o_btn_pulse  output  1  single-cycle press strobe.
REQ-011: o_sw_changed  output  1  single-cycle strobe when any debounced switch bit changes.

Function
REQ-012: Each of the N_SLIDE_SWITCHES+1 inputs SHALL pass through its own two-flop synchronizer before any other logic; sync output = value sampled two edges earlier.
REQ-013: Each input SHALL own one stable register and one counter of width clog2(DEBOUNCE_CYCLES)+1; counters are independent per bit.
REQ-014: Each edge with sync == stable SHALL clear that bit's counter to 0.
REQ-015: Each edge with sync != stable and counter < DEBOUNCE_CYCLES-1 SHALL increment the counter.
REQ-016: Each edge with sync != stable and counter == DEBOUNCE_CYCLES-1 SHALL load stable with sync and clear the counter.
REQ-017: Latency: a raw level held constant SHALL appear on its debounced output exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-018: A raw pulse or glitch lasting fewer than DEBOUNCE_CYCLES cycles at sync output SHALL never change the debounced output; the counter restarts from 0 on the next disagreement.
REQ-019: o_slide_switches and o_btn_level SHALL be driven directly from the stable registers (registered outputs, no combinational path from inputs).
REQ-020: o_btn_pulse SHALL be 1 for exactly the one cycle following the edge where the button stable register goes 0 -> 1; release (1 -> 0) SHALL produce no pulse.
REQ-021: o_sw_changed SHALL be 1 for exactly the one cycle following any edge where one or more switch stable bits change; simultaneous changes of several bits SHALL produce one single-cycle strobe.
REQ-022: Button and switch updates on the same edge SHALL both take effect; o_btn_pulse and o_sw_changed may assert together.

Reset
REQ-023: Asserting i_reset_n low SHALL immediately, without a clock, clear synchronizers, stable registers, counters and the repeat counter to 0.
REQ-024: During reset all outputs SHALL be 0: o_slide_switches = 0, o_btn_level = 0, o_btn_pulse = 0, o_sw_changed = 0.
REQ-025: Reset asserted mid-count SHALL discard partial counts; after release, debouncing restarts from stable = 0 and inputs already high are accepted per REQ-017, with the resulting strobes (REQ-020, REQ-021).
REQ-026: Reset deassertion is synchronized externally; the block SHALL not add a reset synchronizer.

Configuration
REQ-027: Macro INPUT_DEBOUNCER_AUTOREPEAT_EN defined: while o_btn_level stays 1, a 24-bit repeat counter SHALL count edges since the press strobe and o_btn_pulse SHALL additionally assert for one cycle every REPEAT_CYCLES cycles after the initial press pulse.
REQ-028: With the macro defined, the repeat counter SHALL clear when o_btn_level returns to 0, and no pulse SHALL be emitted on release.
REQ-029: Macro undefined: the repeat counter SHALL not exist; o_btn_pulse asserts only per REQ-020.

Verification (DEBOUNCE_CYCLES=4, REQ-027 runs with REPEAT_CYCLES=8)
REQ-030: Reset, then i_slide_switches 8'h00 -> 8'hA5 held -> o_slide_switches = 8'hA5 exactly 6 edges later; o_sw_changed high for one cycle.
REQ-031: i_btn high for 3 cycles, then low -> o_btn_level stays 0, o_btn_pulse never asserts.
REQ-032: i_btn high and held -> o_btn_level = 1 after 6 edges, o_btn_pulse one cycle; release held -> o_btn_level = 0 after 6 edges, no pulse.
REQ-033: Switches 8'hA5 and button accepted on the same edge -> o_btn_pulse and o_sw_changed both high in the same cycle.
REQ-034: i_reset_n pulsed low mid-count with a switch bit 2 edges from acceptance -> all outputs 0 at once; after release, held input reaccepted after a full 6 edges.
REQ-035: Macro defined, button held 40 cycles -> pulses at acceptance and every 8 cycles thereafter, none after release.
